fifo_reader: RTL and testbench
==============================

# fifo_reader

Read-side controller for the team's synchronous FIFO. Drains words through the FIFO's `rd_en`/`dout`/`empty` port and presents them on a valid/ready stream to a downstream consumer. Sits directly on the FIFO read port, on the same clock and reset. It absorbs the FIFO's one-cycle read latency and its registered (one-cycle-lagging) `empty` flag, so downstream logic sees a clean stream with backpressure.

## Interface

Parameters:
- `DATA_WIDTH`, 8: word width; must match the FIFO.
- `PKT_LEN`, 4: words per packet; used only with `FIFO_READER_LAST_EN`; must be ≥1.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`, input, 1: clock; all logic on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `fifo_rd_en`, output, 1: read strobe to the FIFO.
- `fifo_dout`, input, DATA_WIDTH: FIFO read data; valid the cycle after `fifo_rd_en`.
- `fifo_empty`, input, 1: FIFO empty flag; registered and lags FIFO occupancy by one cycle.
- `m_valid`, output, 1: output word valid.
- `m_ready`, input, 1: downstream accepts the word.
- `m_data`, output, DATA_WIDTH: output word.
- `m_last`, output, 1: last word of a packet. Present only with `FIFO_READER_LAST_EN`.

## Operation

- FSM states:
  - `IDLE`: go to `READ` when `!fifo_empty && occ < 2`; otherwise stay in `IDLE`.
  - `READ`: `fifo_rd_en = 1`, decoded from the state register only. Always go to `CAPTURE`.
  - `CAPTURE`: write `fifo_dout` into the output buffer, `occ` +1. Always go to `IDLE`.
- `CAPTURE` never chains directly into `READ`. `fifo_empty` is stale during `CAPTURE`, so re-evaluation happens in `IDLE`, where the flag is correct. This guarantees no read is ever issued against an empty FIFO.
- Output buffer:
  - 2 entries, FIFO-ordered.
  - `occ` is 2 bits wide, range 0..2.
  - `m_valid = (occ != 0)`; `m_data` is the head entry.
  - Pop on `m_valid && m_ready`.
  - Push in `CAPTURE` and pop in the same cycle: `occ` is unchanged and order is preserved.
- Backpressure:
  - With `occ == 2`, the FSM holds in `IDLE` and `fifo_rd_en` stays 0.
  - The `occ < 2` check at `IDLE` is sufficient: at most one word is in flight, and pops only free space.
- Words are neither dropped nor duplicated. The output order equals the FIFO read order.
- `m_data` and `m_valid` must stay stable while `m_valid && !m_ready`.

## Timing

- Reset values:
  - `fifo_rd_en` 0, `m_valid` 0, `m_data` 0, `m_last` 0.
  - State `IDLE`, `occ` 0, packet counter 0.
- Reset mid-operation:
  - Takes effect at the next edge and wins over every other update.
  - An in-flight word (state `CAPTURE`) is discarded and buffered words are flushed.
  - The FIFO shares `rst`, so no data outlives the reset.
- Latency: `fifo_empty` low in cycle t, with space available:
  - `fifo_rd_en` high in t+1.
  - Capture in t+2.
  - `m_valid` high in t+3.
- Throughput: at most one word every 3 cycles (`IDLE`→`READ`→`CAPTURE`).
- `fifo_rd_en` is high for exactly one cycle per read and is never high in two consecutive cycles.

## Configuration

- Macro: `FIFO_READER_LAST_EN`.
- When defined:
  - A packet counter of width `$clog2(PKT_LEN)` (minimum 1 bit) counts popped words.
  - `m_last = m_valid && (cnt == PKT_LEN-1)`.
  - The counter wraps to 0 on the pop where `m_last` is high.
  - The counter advances only on handshakes.
- When undefined: no `m_last` port, no packet counter, and all other behaviour is identical.

## Structure

- Shared package `fifo_reader_pkg`:
  - State enum `IDLE`/`READ`/`CAPTURE`.
  - Buffer depth constant (2).
  - `occ` width.
- Sub-module `fifo_reader_skid`: the 2-entry output buffer, with push/pop/occupancy, `m_valid`/`m_data` generation and stall stability. The FSM stays in `fifo_reader`.

## Test plan

- Reset: assert `rst` 2 cycles with `fifo_empty=0` → `fifo_rd_en`, `m_valid` and `m_data` are 0 throughout reset. The first `fifo_rd_en` occurs exactly 1 cycle after `rst` deassert (`IDLE` at the deassert cycle).
- Stream, no stall: FIFO holds 0x11,0x22,0x33,0x44; `m_ready=1` → `fifo_rd_en` pulses at cycles 1,4,7,10. `m_valid` is high in cycles 3,6,9,12 with data in order 0x11..0x44. No read is issued after the flag shows empty.
- Backpressure: 4 words preloaded, `m_ready=0` → after 2 captures `occ=2` and `fifo_rd_en` stays 0; `m_data` holds 0x11. Raising `m_ready` → 0x11,0x22 drain, reads resume, and all 4 words are delivered once, in order.
- Single word then empty: 1 word 0xA5 written → exactly one `fifo_rd_en` pulse and 0xA5 delivered. No second rd_en while the lagging `fifo_empty` settles.
- Reset mid-transfer: assert `rst` in the `CAPTURE` cycle with `occ=1` → the next cycle has `m_valid=0`, `occ=0` and state `IDLE`. The in-flight word is never presented.
- With `FIFO_READER_LAST_EN`, `PKT_LEN=3`: 6 words streamed → `m_last` is high on words 3 and 6 only. Stalling on word 3 for 4 cycles keeps `m_last` high and the counter frozen.

Source files
------------

// File: rtl/fifo_reader_pkg.sv
// Shared definitions for fifo_reader: state encoding, output buffer depth and
// occupancy width, and the packet-counter width helper.
package fifo_reader_pkg;

  localparam int BUF_DEPTH = 2;
  localparam int OCC_W     = 2;

  typedef logic [OCC_W-1:0] occ_t;
  typedef logic [1:0]       state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_READ    = 2'd1;
  localparam state_t ST_CAPTURE = 2'd2;

  // Packet counter width; a one-word packet still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry, in-order output buffer for fifo_reader. The head entry always
// sits in slot 0 so m_data is a plain register output that holds during stalls.
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output occ_t                  o_occ
);

  logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
  occ_t                  r_occ;
  logic                  w_pop;

  assign o_valid = (r_occ != '0);
  assign o_data  = r_mem[0];
  assign o_occ   = r_occ;
  assign w_pop   = o_valid && i_ready;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  // NOTE: both data slots are reset, not just the occupancy, so m_data reads 0
  // out of reset; acceptable for two entries, not for a RAM-sized buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ    <= '0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else begin
      unique case ({i_push, w_pop})
        2'b10: begin
          r_mem[r_occ[0]] <= i_push_data;
          r_occ           <= r_occ + occ_t'(1);
        end
        2'b01: begin
          r_mem[0] <= r_mem[1];
          r_occ    <= r_occ - occ_t'(1);
        end
        2'b11: begin
          // Simultaneous push and pop: the new word lands behind whatever stays.
          if (r_occ == occ_t'(1)) begin
            r_mem[0] <= i_push_data;
          end else begin
            r_mem[0] <= r_mem[1];
            r_mem[1] <= i_push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Read-side controller for the synchronous FIFO: IDLE/READ/CAPTURE sequencer
// feeding a 2-entry valid/ready buffer. Optional m_last via FIFO_READER_LAST_EN.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_READER_LAST_EN
  ,
  output logic                  m_last
`endif
);

  state_t r_state;
  state_t w_state_nxt;
  occ_t   w_occ;
  logic   w_capture;

  if (PKT_LEN < 1) begin : g_bad_pkt_len
    $error("fifo_reader: PKT_LEN must be >= 1");
  end

  // Return to IDLE after every capture: fifo_empty is stale during CAPTURE.
  // NOTE: next-state starts from a default so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (!fifo_empty && (w_occ < occ_t'(BUF_DEPTH))) w_state_nxt = ST_READ;
      end
      ST_READ:    w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  assign fifo_rd_en = (r_state == ST_READ);
  assign w_capture  = (r_state == ST_CAPTURE);

  fifo_reader_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_capture),
    .i_push_data (fifo_dout),
    .i_ready     (m_ready),
    .o_valid     (m_valid),
    .o_data      (m_data),
    .o_occ       (w_occ)
  );

`ifdef FIFO_READER_LAST_EN
  localparam int CNT_W = cnt_width(PKT_LEN);

  logic [CNT_W-1:0] r_cnt;
  logic             w_pop;

  assign w_pop  = m_valid && m_ready;
  assign m_last = m_valid && (r_cnt == CNT_W'(PKT_LEN - 1));

  // Counts accepted words only, so a stalled last word keeps m_last asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_pop) begin
      r_cnt <= m_last ? '0 : r_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: behavioural FIFO with a lagging empty
// flag, scoreboard of expected words, and per-scenario directed tasks.
module tb_fifo_reader;

  localparam int DW = 8;
`ifdef FIFO_READER_LAST_EN
  localparam int PKT = 3;
`else
  localparam int PKT = 4;
`endif

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_dout  = '0;
  logic          fifo_empty = 1'b1;
  logic          m_valid;
  logic          m_ready    = 1'b0;
  logic [DW-1:0] m_data;
`ifdef FIFO_READER_LAST_EN
  logic          m_last;
`endif

  int checks     = 0;
  int errors     = 0;
  int delivered  = 0;
  int last_seen  = 0;
  int pkt_cnt    = 0;

  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] sb_q   [$];

  logic          prev_stall = 1'b0;
  logic          prev_rd    = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  logic [DW-1:0] exp_d;
  logic          exp_last;

  always #5 clk = ~clk;

  fifo_reader #(
    .DATA_WIDTH (DW),
    .PKT_LEN    (PKT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data)
`ifdef FIFO_READER_LAST_EN
    ,
    .m_last     (m_last)
`endif
  );

  // FIFO model: one-cycle read latency, empty flag registered from the
  // occupancy of the cycle that just ended.
  always @(posedge clk) begin
    fifo_empty <= (fifo_q.size() == 0);
    if (fifo_rd_en && !rst) begin
      checks++;
      if (fifo_q.size() == 0) begin
        errors++;
        $display("FAIL read_on_empty: fifo_rd_en=1 with occupancy 0, required no read");
      end else begin
        fifo_dout <= fifo_q.pop_front();
      end
    end
  end

  // Output monitor: scoreboard, stall stability, rd_en spacing, m_last model.
  always @(negedge clk) begin
    if (prev_rd) begin
      checks++;
      if (fifo_rd_en !== 1'b0) begin
        errors++;
        $display("FAIL rd_en_spacing: got fifo_rd_en=%b after a read cycle, required 0", fifo_rd_en);
      end
    end
    prev_rd = fifo_rd_en;
    if (rst) begin
      prev_stall = 1'b0;
      pkt_cnt    = 0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: got valid=%b data=%h, required valid=1 data=%h",
                   m_valid, m_data, prev_data);
        end
      end
      exp_last = m_valid && (pkt_cnt == PKT - 1);
`ifdef FIFO_READER_LAST_EN
      checks++;
      if (m_last !== exp_last) begin
        errors++;
        $display("FAIL m_last: got %b, required %b (word index %0d in packet)", m_last, exp_last, pkt_cnt);
      end
`endif
      if (m_valid && m_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got data=%h, required no word", m_data);
        end else begin
          exp_d = sb_q.pop_front();
          if (m_data !== exp_d) begin
            errors++;
            $display("FAIL stream_data: got %h, required %h", m_data, exp_d);
          end
        end
        delivered++;
        if (exp_last) last_seen++;
        pkt_cnt = (pkt_cnt == PKT - 1) ? 0 : pkt_cnt + 1;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    tick();
    rst     = 1'b1;
    m_ready = 1'b0;
    fifo_q.delete();
    sb_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) fifo_q.push_back(DW'(8'h11 * (i + 1)));
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks += 3;
      if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b, required 0", fifo_rd_en); end
      if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", m_valid); end
      if (m_data !== '0) begin errors++; $display("FAIL reset_data: got %h, required 00", m_data); end
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_release_idle: got rd_en=%b, required 0", fifo_rd_en); end
    @(negedge clk);
    checks++;
    if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL reset_first_read: got rd_en=%b, required 1", fifo_rd_en); end
    apply_reset();
  endtask

  task automatic test_stream();
    logic [15:0] rd_mask;
    logic [15:0] v_mask;
    bit          found;
    tick();
    for (int i = 0; i < 4; i++) begin
      fifo_q.push_back(DW'(8'h11 * (i + 1)));
      sb_q.push_back(DW'(8'h11 * (i + 1)));
    end
    m_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      found = !fifo_empty;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL stream_timeout: got empty=1, required 0 within 8 cycles"); end
    rd_mask = '0;
    v_mask  = '0;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      rd_mask[c] = fifo_rd_en;
      v_mask[c]  = m_valid;
    end
    checks += 3;
    if (rd_mask !== 16'h0492) begin errors++; $display("FAIL stream_rd_cycles: got %h, required 0492", rd_mask); end
    if (v_mask !== 16'h1248) begin errors++; $display("FAIL stream_valid_cycles: got %h, required 1248", v_mask); end
    if (sb_q.size() != 0) begin errors++; $display("FAIL stream_drained: got %0d pending, required 0", sb_q.size()); end
  endtask

  task automatic test_backpressure();
    int rd_cnt;
    int d0;
    tick();
    for (int i = 0; i < 4; i++) begin
      fifo_q.push_back(DW'(8'h11 * (i + 1)));
      sb_q.push_back(DW'(8'h11 * (i + 1)));
    end
    m_ready = 1'b0;
    rd_cnt  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rd_cnt += int'(fifo_rd_en);
    end
    checks += 3;
    if (rd_cnt != 2) begin errors++; $display("FAIL bp_reads: got %0d reads, required 2", rd_cnt); end
    if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b, required 1", m_valid); end
    if (m_data !== 8'h11) begin errors++; $display("FAIL bp_head: got %h, required 11", m_data); end
    tick();
    d0 = delivered;
    m_ready = 1'b1;
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checks += 3;
    if (sb_q.size() != 0) begin errors++; $display("FAIL bp_drain_timeout: got %0d pending, required 0", sb_q.size()); end
    if (delivered - d0 != 4) begin errors++; $display("FAIL bp_count: got %0d words, required 4", delivered - d0); end
    if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_final_valid: got %b, required 0", m_valid); end
  endtask

  task automatic test_single_word();
    int rd_cnt;
    int d0;
    tick();
    fifo_q.push_back(8'hA5);
    sb_q.push_back(8'hA5);
    m_ready = 1'b1;
    d0      = delivered;
    rd_cnt  = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      rd_cnt += int'(fifo_rd_en);
    end
    checks += 2;
    if (rd_cnt != 1) begin errors++; $display("FAIL single_reads: got %0d reads, required 1", rd_cnt); end
    if (delivered - d0 != 1) begin errors++; $display("FAIL single_count: got %0d words, required 1", delivered - d0); end
  endtask

  task automatic test_reset_mid();
    bit found;
    int v_cnt;
    int rd_cnt;
    int d0;
    tick();
    fifo_q.push_back(8'h5A);
    fifo_q.push_back(8'h6B);
    sb_q.push_back(8'h5A);
    sb_q.push_back(8'h6B);
    m_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = fifo_rd_en && m_valid;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL mid_timeout: got no second read, required one within 20 cycles"); end
    tick();
    rst = 1'b1;
    fifo_q.delete();
    sb_q.delete();
    tick();
    rst     = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    checks += 3;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b, required 0", m_valid); end
    if (m_data !== '0) begin errors++; $display("FAIL mid_data: got %h, required 00", m_data); end
    if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL mid_rd_en: got %b, required 0", fifo_rd_en); end
    d0     = delivered;
    v_cnt  = 0;
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      v_cnt  += int'(m_valid);
      rd_cnt += int'(fifo_rd_en);
    end
    checks += 2;
    if (v_cnt != 0 || delivered != d0) begin
      errors++;
      $display("FAIL mid_discard: got %0d valid cycles and %0d words, required 0 and 0", v_cnt, delivered - d0);
    end
    if (rd_cnt != 0) begin errors++; $display("FAIL mid_no_read: got %0d reads, required 0", rd_cnt); end
  endtask

`ifdef FIFO_READER_LAST_EN
  task automatic test_last();
    int  local_cnt;
    int  l0;
    int  d0;
    bit  found;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      fifo_q.push_back(DW'(8'h61 + i));
      sb_q.push_back(DW'(8'h61 + i));
    end
    m_ready   = 1'b1;
    local_cnt = 0;
    l0        = last_seen;
    d0        = delivered;
    for (int i = 0; i < 80 && local_cnt < 2; i++) begin
      @(negedge clk);
      if (m_valid && m_ready) local_cnt++;
    end
    tick();
    m_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = m_valid;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL last_timeout: got no third word, required one within 20 cycles"); end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (m_last !== 1'b1 || m_data !== 8'h63) begin
        errors++;
        $display("FAIL last_stall: got last=%b data=%h, required last=1 data=63", m_last, m_data);
      end
    end
    tick();
    m_ready = 1'b1;
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checks += 2;
    if (last_seen - l0 != 2) begin errors++; $display("FAIL last_count: got %0d last words, required 2", last_seen - l0); end
    if (delivered - d0 != 6) begin errors++; $display("FAIL last_words: got %0d words, required 6", delivered - d0); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_single_word();
    test_reset_mid();
`ifdef FIFO_READER_LAST_EN
    test_last();
`endif
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
